// File: rtl/inst_fetch_buffer.sv
// -----------------------------------------------------------------------------
// inst_fetch_buffer
//
// Instruction fetch front end for the openmips minimal SOPC. It sits between
// inst_rom and the IF/ID stage: it generates the fetch PC, requests words from
// inst_rom (read data arrives one cycle after the request), and parks every
// returned instruction together with its PC in a small FIFO. ID stalls and
// branch redirects therefore never lose or duplicate an instruction, and the
// unit sustains one instruction per cycle when ID is not stalling.
//
// Parameters
//   DEPTH     FIFO entries (power of 2, 2..4; the count port is 3 bits wide)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   asynchronous reset, active low (0 = reset)
//   rom_ce_o         out  inst_rom read enable, one request per high cycle
//   rom_addr_o       out  inst_rom byte address (registered fetch PC)
//   rom_data_i       in   inst_rom data, valid the cycle after rom_ce_o=1
//   stall_i          in   ID cannot accept the head entry this cycle
//   branch_flag_i    in   redirect fetch this cycle
//   branch_target_i  in   redirect address, sampled when branch_flag_i=1
//   if_valid_o       out  head entry valid
//   if_pc_o          out  head entry PC (0 when empty)
//   if_inst_o        out  head entry instruction (0 when empty)
//   fifo_count_o     out  entries currently held (0..DEPTH)
//
// Handshake: the head entry is offered whenever if_valid_o=1 and is consumed
// on the rising edge of any cycle in which if_valid_o=1 and stall_i=0 (and no
// branch is being taken); while stall_i=1 the head pc/inst stay stable.
// -----------------------------------------------------------------------------
module inst_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic [2:0]  fifo_count_o
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] FULL_C  = 3'(DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  // Fetch state
  logic        run_q, run_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] req_pc_q, req_pc_d;       // PC of the request now in flight

  // FIFO state
  logic [2:0]    count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   pc_mem_d   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];

  logic [3:0] occupancy;
  logic       push;
  logic       pop;

  // ---------------------------------------------------------------------------
  // Outputs and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // A new request is only allowed if every word already held or still on its
    // way from the ROM fits; a pop in the same cycle is deliberately not
    // credited, which keeps the issue decision independent of stall_i.
    occupancy  = {1'b0, count_q} + {3'b000, inflight_q};
    rom_ce_o   = run_q & ~branch_flag_i & (occupancy < DEPTH_C);
    rom_addr_o = fetch_pc_q;

    if_valid_o   = (count_q != 3'd0);
    if_pc_o      = if_valid_o ? pc_mem_q[rd_ptr_q]   : 32'h0;
    if_inst_o    = if_valid_o ? inst_mem_q[rd_ptr_q] : 32'h0;
    fifo_count_o = count_q;

    // A branch discards the word returning this cycle and overrides the pop.
    push = inflight_q & ~branch_flag_i;
    pop  = if_valid_o & ~stall_i & ~branch_flag_i;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    run_d      = 1'b1;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = rom_ce_o;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;

    if (branch_flag_i) begin
      // Redirect: flush everything; rom_ce_o is already low so nothing is
      // left in flight after this edge.
      fetch_pc_d = branch_target_i;
      count_d    = 3'd0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (rom_ce_o) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        req_pc_d   = fetch_pc_q;
      end

      if (push) begin
        pc_mem_d[wr_ptr_q]   = req_pc_q;
        inst_mem_d[wr_ptr_q] = rom_data_i;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end

      case ({push, pop})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      req_pc_q   <= RESET_PC;
      count_q    <= 3'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pc_mem_q   <= '{default: 32'h0};
      inst_mem_q <= '{default: 32'h0};
    end else begin
      run_q      <= run_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end

  // The issue rule guarantees a free slot for every returning word.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count_q == FULL_C)));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
`timescale 1ns/1ps
module tb_inst_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] K        = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic [2:0]  fifo_count_o;

  int n_checks;
  int n_errors;
  int n_pops;

  // Scoreboard: PCs the consumer must see next, in order.
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_data_i      (rom_data_i),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .if_valid_o      (if_valid_o),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .fifo_count_o    (fifo_count_o)
  );

  // ---------------------------------------------------------------- clock/reset
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM: data one cycle after the request.
  always @(posedge clk) begin
    if (rom_ce_o) rom_data_i <= rom_addr_o ^ K;
  end

  // ---------------------------------------------------------------- checkers
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: after a redirect (or reset) the consumer sees a gapless
  // ascending word stream starting at the redirect address.
  task automatic redirect(input logic [31:0] tgt);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(tgt + 32'(i * 4));
  endtask

  // ---------------------------------------------------------------- driver
  task automatic cyc(input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    stall_i         = s;
    branch_flag_i   = b;
    branch_target_i = t;
    if (b) redirect(t);
    #1;
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    #2;
    if (rst && if_valid_o && !stall_i && !branch_flag_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL mon_exp_q_empty: got pc %h expected none", if_pc_o);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("mon_pc", if_pc_o, mon_exp);
        chk("mon_inst", if_inst_o, mon_exp ^ K);
        n_pops++;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  logic [31:0] hold_pc, hold_inst;
  logic        hold_prev;

  initial begin
    n_checks = 0; n_errors = 0; n_pops = 0;
    rst = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
    redirect(RESET_PC);
    #1;
    chk1("rst_ce", rom_ce_o, 1'b0);
    chk ("rst_addr", rom_addr_o, RESET_PC);
    chk1("rst_valid", if_valid_o, 1'b0);
    chk ("rst_pc", if_pc_o, 32'h0);
    chk ("rst_inst", if_inst_o, 32'h0);
    chk ("rst_count", 32'(fifo_count_o), 32'd0);

    // 1. release reset at 195 ns
    repeat (10) @(negedge clk);
    #1;
    chk1("rst_hold_ce", rom_ce_o, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("ce_before_run", rom_ce_o, 1'b0);
    cyc(0, 0, 0);
    chk1("first_req_ce", rom_ce_o, 1'b1);
    chk ("first_req_addr", rom_addr_o, 32'h0);
    chk1("first_req_valid", if_valid_o, 1'b0);
    cyc(0, 0, 0);
    chk ("second_req_addr", rom_addr_o, 32'h4);
    chk1("latency_valid_lo", if_valid_o, 1'b0);
    cyc(0, 0, 0);
    chk ("third_req_addr", rom_addr_o, 32'h8);
    chk1("latency_valid_hi", if_valid_o, 1'b1);
    chk ("first_pc", if_pc_o, 32'h0);

    // 2. steady streaming
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0);
      chk ("stream_count", 32'(fifo_count_o), 32'd1);
      chk1("stream_valid", if_valid_o, 1'b1);
      chk1("stream_ce", rom_ce_o, 1'b1);
    end

    // 3. stall for 10 cycles
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0);
      if (i == 0) begin
        hold_pc = if_pc_o; hold_inst = if_inst_o;
      end else begin
        chk("stall_hold_pc", if_pc_o, hold_pc);
        chk("stall_hold_inst", if_inst_o, hold_inst);
      end
    end
    chk ("stall_full_count", 32'(fifo_count_o), 32'd4);
    chk1("stall_full_ce", rom_ce_o, 1'b0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0);
    chk("drain_count", 32'(fifo_count_o), 32'd2);

    // 4. branch with count=2, inflight=1
    cyc(0, 1, 32'h100);
    chk ("br_count_pre", 32'(fifo_count_o), 32'd2);
    chk1("br_ce", rom_ce_o, 1'b0);
    cyc(0, 0, 0);
    chk1("br_next_ce", rom_ce_o, 1'b1);
    chk ("br_next_addr", rom_addr_o, 32'h100);
    chk ("br_next_count", 32'(fifo_count_o), 32'd0);
    chk1("br_valid_b1", if_valid_o, 1'b0);
    cyc(0, 0, 0);
    chk1("br_valid_b2", if_valid_o, 1'b0);
    cyc(0, 0, 0);
    chk1("br_valid_b3", if_valid_o, 1'b1);
    chk ("br_first_pc", if_pc_o, 32'h100);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);

    // 5. branch while full and stalled
    for (int i = 0; i < 8; i++) cyc(1, 0, 0);
    chk("full_count", 32'(fifo_count_o), 32'd4);
    cyc(1, 1, 32'h200);
    chk1("full_br_ce", rom_ce_o, 1'b0);
    cyc(0, 0, 0);
    chk ("full_br_count", 32'(fifo_count_o), 32'd0);
    chk ("full_br_addr", rom_addr_o, 32'h200);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk ("full_br_first_pc", if_pc_o, 32'h200);

    // address wrap mod 2^32
    cyc(0, 1, 32'hFFFF_FFF8);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("wrap_pc0", if_pc_o, 32'hFFFF_FFF8);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("wrap_pc2", if_pc_o, 32'h0);

    // randomized stall / branch traffic
    hold_prev = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic s, b;
      logic [31:0] t;
      s = ($urandom_range(0, 9) < 4);
      b = ($urandom_range(0, 19) == 0);
      t = 32'($urandom_range(0, 1023)) << 2;
      cyc(s, b, t);
      chk1("rnd_count_le", (fifo_count_o <= 3'd4), 1'b1);
      chk1("rnd_valid_eq", if_valid_o, (fifo_count_o != 3'd0));
      if (!if_valid_o) begin
        chk("rnd_empty_pc", if_pc_o, 32'h0);
        chk("rnd_empty_inst", if_inst_o, 32'h0);
      end
      if (b) chk1("rnd_br_ce", rom_ce_o, 1'b0);
      if (hold_prev) begin
        chk("rnd_hold_pc", if_pc_o, hold_pc);
        chk("rnd_hold_inst", if_inst_o, hold_inst);
      end
      hold_prev = if_valid_o & s & ~b;
      hold_pc   = if_pc_o;
      hold_inst = if_inst_o;
    end

    // 6. asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) cyc(0, 0, 0);
    @(negedge clk);
    stall_i = 1'b0; branch_flag_i = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk1("async_ce", rom_ce_o, 1'b0);
    chk1("async_valid", if_valid_o, 1'b0);
    chk ("async_count", 32'(fifo_count_o), 32'd0);
    chk ("async_pc", if_pc_o, 32'h0);
    chk ("async_inst", if_inst_o, 32'h0);
    chk ("async_addr", rom_addr_o, RESET_PC);
    redirect(RESET_PC);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("restart_ce0", rom_ce_o, 1'b0);
    cyc(0, 0, 0);
    chk1("restart_ce1", rom_ce_o, 1'b1);
    chk ("restart_addr", rom_addr_o, RESET_PC);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk1("restart_valid", if_valid_o, 1'b1);
    chk ("restart_pc", if_pc_o, RESET_PC);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);

    chk1("pops_seen", (n_pops > 100), 1'b1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
